// File: rtl/chacha_pkg.sv
// Shared ChaCha20 types: words, 4x4 state matrix, block size and
// the deserialiser fill/full state.
package chacha_pkg;
   typedef logic [31:0] word_t;
   typedef word_t [3:0][3:0] mat_t;

   localparam int WORDS_PER_BLOCK = 16;
   localparam logic [3:0] LAST_IDX = 4'(WORDS_PER_BLOCK - 1);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;
endpackage

// File: rtl/word_byteswap.sv
// Combinational 32-bit byte reverser: big-endian stream word to
// little-endian ChaCha20 word.
module word_byteswap
   import chacha_pkg::*;
(
   input  word_t i_word,
   output word_t o_word
);
   assign o_word = {i_word[7:0], i_word[15:8],
                    i_word[23:16], i_word[31:24]};
endmodule

// File: rtl/deserialiser.sv
// Serial word stream to 4x4 word matrix, first word into [3][3].
// Define DESERIALISER_BYTESWAP_EN to byte-reverse each stored word.
module deserialiser
   import chacha_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  flush,
   input  word_t in_data,
   input  logic  in_valid,
   input  logic  in_last,
   output logic  in_ready,
   output mat_t  out_data,
   output logic  out_valid,
   input  logic  out_ready,
   output logic  err
);
   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_idx;
   logic       r_in_ready;
   logic       r_out_valid;
   logic       r_err;
   mat_t       r_data;

   word_t      w_word;
   logic       w_acc;
   logic       w_at_last;
   logic       w_mis;
   logic       w_done;
   logic       w_in_ready_nxt;
   logic       w_out_valid_nxt;
   logic       w_err_nxt;

`ifdef DESERIALISER_BYTESWAP_EN
   word_byteswap u_swap (
      .i_word (in_data),
      .o_word (w_word)
   );
`else
   assign w_word = in_data;
`endif

   assign w_acc     = in_valid & r_in_ready;
   assign w_at_last = (r_idx == LAST_IDX);
   assign w_mis     = w_acc & (in_last != w_at_last);
   assign w_done    = w_acc & in_last & w_at_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= FILL;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = FILL;
      end else begin
         unique case (r_state)
            FILL: if (w_done)    w_next = FULL;
            FULL: if (out_ready) w_next = FILL;
         endcase
      end
   end

   // Handshake outputs are registered copies of the next state.
   always_comb begin
      w_in_ready_nxt  = (w_next == FILL);
      w_out_valid_nxt = (w_next == FULL);
      w_err_nxt       = ~flush & w_mis;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_err       <= w_err_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (flush) begin
         r_idx <= '0;
      end else if (w_acc) begin
         if (w_mis || w_at_last) r_idx <= '0;
         else                    r_idx <= r_idx + 4'd1;
      end
   end

   // Inverted index bits give the reversed row/column placement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else if (!flush && w_acc) begin
         r_data[~r_idx[3:2]][~r_idx[1:0]] <= w_word;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign err       = r_err;
   assign out_data  = r_data;
endmodule

// File: tb/tb_deserialiser.sv
// Scoreboard bench for deserialiser: expected blocks are queued at
// stimulus time and compared by a monitor on each consumed block.
module tb_deserialiser;
   import chacha_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n = 1'b1;
   logic  flush = 1'b0;
   word_t in_data = '0;
   logic  in_valid = 1'b0;
   logic  in_last = 1'b0;
   logic  in_ready;
   mat_t  out_data;
   logic  out_valid;
   logic  out_ready = 1'b0;
   logic  err;

   int    n_chk = 0;
   int    n_fail = 0;
   mat_t  exp_q[$];

   deserialiser dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic word_t model_word(word_t w);
`ifdef DESERIALISER_BYTESWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   function automatic mat_t mk_block(word_t base);
      mat_t m;
      m = '0;
      for (int i = 0; i < 16; i++)
         m[3 - i / 4][3 - i % 4] = model_word(base + word_t'(i));
      return m;
   endfunction

   task automatic check(string name, logic [31:0] act,
                        logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_mat(string name, mat_t act, mat_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               if (act[r][c] !== exp[r][c])
                  $display("FAIL %s [%0d][%0d]: got %h expected %h",
                           name, r, c, act[r][c], exp[r][c]);
      end
   endtask

   // Monitor: a block is consumed when out_valid && out_ready.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL block: unexpected block [3][3]=%h",
                     out_data[3][3]);
         end else begin
            check_mat("block", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic send(word_t d, logic last);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: in_ready got 0 expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_block(word_t base);
      exp_q.push_back(mk_block(base));
      for (int i = 0; i < 16; i++)
         send(base + word_t'(i), i == 15);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check_mat("rst_out_data", out_data, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rel_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("rise_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;

      // Basic block with latency checks.
      send_block(32'h0000_0000);
      check("lat_out_valid", 32'(out_valid), 32'd1);
      check("lat_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("cons_out_valid", 32'(out_valid), 32'd0);
      check("cons_in_ready", 32'(in_ready), 32'd1);

      // Back-pressure: block held for 5 cycles.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send_block(32'h0000_0100);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 32'hDEAD_BEEF;
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check_mat("hold_data", out_data, mk_block(32'h0000_0100));
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      send_block(32'h0000_0200);

      // Early in_last on word 10.
      for (int i = 0; i < 9; i++)
         send(32'h0000_0300 + word_t'(i), 1'b0);
      send(32'h0000_0309, 1'b1);
      check("early_err", 32'(err), 32'd1);
      check("early_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1 check("early_err_clr", 32'(err), 32'd0);
      send_block(32'h0000_0400);

      // Missing in_last on word 16.
      for (int i = 0; i < 16; i++)
         send(32'h0000_0500 + word_t'(i), 1'b0);
      check("miss_err", 32'(err), 32'd1);
      check("miss_out_valid", 32'(out_valid), 32'd0);
      check("miss_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 check("miss_err_clr", 32'(err), 32'd0);
      send_block(32'h0000_0600);

      // Flush after 7 words, with a word in the same cycle.
      for (int i = 0; i < 7; i++)
         send(32'h0000_0700 + word_t'(i), 1'b0);
      @(negedge clk);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hBAD0_BAD0;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_err", 32'(err), 32'd0);
      @(posedge clk);
      #1;
      check("flush_err2", 32'(err), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      send_block(32'h0000_0800);

      // Reset mid-block.
      for (int i = 0; i < 5; i++)
         send(32'h0000_0900 + word_t'(i), 1'b0);
      rst_n = 1'b0;
      #1;
      check("mrst_in_ready", 32'(in_ready), 32'd0);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_err", 32'(err), 32'd0);
      check_mat("mrst_out_data", out_data, '0);
      @(negedge clk);
      rst_n = 1'b1;
      send_block(32'h0000_0A00);

`ifdef DESERIALISER_BYTESWAP_EN
      @(posedge clk);
      #1 out_ready = 1'b0;
      send_block(32'h1122_3344);
      check("swap_33", out_data[3][3], 32'h4433_2211);
      out_ready = 1'b1;
`endif

      for (int n = 0; n < 200 && exp_q.size() != 0; n++)
         @(posedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: blocks pending %0d expected 0",
                  exp_q.size());
      end
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
